tb_run_ctrl: RTL and testbench
==============================

// Module: tb_run_ctrl
// PURPOSE
//  Parametrised simulation run controller for CPU top-level benches.
//  - Sequences DUT reset and watches N error sources, halt, a global timeout and a commit-stall watchdog.
//  - Drains after errors, then raises a sticky done with a status code; the bench calls $finish on done.
//  - Replaces per-bench reset/timeout/halt/error glue in top-level testbenches.
// PARAMETERS
//  NUM_ERR      2         number of error inputs (mem itf, monitor, ...), >=1
//  RST_CYCLES   5         cycles dut_rst is held after rst deasserts, >=1
//  TIMEOUT      10000000  max cycles in RUN before TIMEOUT status, >=1
//  STALL_LIMIT  0         max consecutive RUN cycles without commit_valid; 0 = watchdog disabled
//  DRAIN_ERR    5         cycles waited after an error event before done
//  CNT_W        32        width of cycle/commit counters; must hold TIMEOUT
// PORTS
//  clk           in   1        bench clock
//  rst           in   1        synchronous active-high reset
//  halt          in   1        monitor halt indication
//  commit_valid  in   1        monitor valid (one instruction retired)
//  err           in   NUM_ERR  error flags, any nonzero bit = error
//  dut_rst       out  1        reset driven to DUT
//  running       out  1        high in RUN state
//  done          out  1        sticky completion flag
//  status        out  3        0 NONE, 1 PASS(halt), 2 ERROR, 3 TIMEOUT, 4 STALL
//  err_latched   out  NUM_ERR  OR of all err bits seen in RUN/DRAIN
//  cycle_cnt     out  CNT_W    cycles spent in RUN
//  commit_cnt    out  CNT_W    commit_valid pulses seen in RUN
// BEHAVIOUR
//  - Single clock domain; all state updates on posedge clk.
//  - rst=1 (synchronous, active-high), including mid-run:
//    - next state RESET_HOLD; dut_rst=1; running=0; done=0; status=0.
//    - err_latched, cycle_cnt, commit_cnt and all internal counters cleared.
//  - FSM: RESET_HOLD -> RUN -> (DRAIN) -> DONE; DONE is terminal until rst.
//  - RESET_HOLD: hold counter increments each cycle with rst=0.
//    - After RST_CYCLES such edges, dut_rst falls and state becomes RUN on the same edge.
//    - halt, err and commit_valid are ignored in RESET_HOLD.
//  - RUN: running=1, dut_rst=0.
//    - cycle_cnt +1 per cycle; commit_cnt +1 per commit_valid.
//    - Both counters saturate at all-ones.
//    - Stall counter clears on commit_valid and otherwise increments.
//  - RUN event detection (same cycle as the input):
//    - error: |err
//    - halt: halt
//    - timeout: cycle_cnt == TIMEOUT-1
//    - stall: STALL_LIMIT != 0 and stall counter == STALL_LIMIT-1 and !commit_valid
//  - Simultaneous events use priority ERROR > PASS > TIMEOUT > STALL.
//    - A commit_valid arriving with halt is still counted.
//  - On an event:
//    - status is latched; err bits are ORed into err_latched; cycle_cnt and commit_cnt freeze.
//    - ERROR with DRAIN_ERR>0 -> DRAIN; otherwise -> DONE on the next edge.
//  - DRAIN: lasts exactly DRAIN_ERR cycles, then DONE.
//    - err keeps ORing into err_latched; halt is ignored; status is not changed.
//  - DONE: done=1 (sticky), running=0, dut_rst=0; all outputs hold until rst.
//  - Latency: done rises one edge after the event (PASS/TIMEOUT/STALL), or 1+DRAIN_ERR edges after an ERROR event.
// TESTING
//  - Reset sequencing: rst high 3 cycles, then low -> dut_rst low exactly 5 edges later; running=1; counters 0.
//  - Halt pass: commit_valid on 10 cycles, halt at RUN cycle 20 -> next edge done=1, status=1, commit_cnt=10, cycle_cnt=20.
//  - Error drain: err=2'b01 at RUN cycle 7, err=2'b10 two cycles later -> done 6 edges after first error, status=2, err_latched=2'b11.
//  - Timeout: TIMEOUT=50, no halt -> done one edge after RUN cycle 50, status=3, cycle_cnt=49.
//  - Stall/priority: STALL_LIMIT=8, no commits -> status=4 after 8 RUN cycles; halt and err in the same cycle -> status=2.
//  - Mid-run reset: rst pulse in DRAIN -> dut_rst=1, done=0, status=0, err_latched=0 on that edge; full sequence repeats.

Source files
------------

// File: rtl/tb_run_ctrl_if.sv
// tb_run_ctrl_if
//   Bundles the run controller's monitor inputs and status outputs.
//   master : the bench side (drives halt, commit_valid, err; observes the rest)
//   slave  : the controller side (observes halt, commit_valid, err; drives the rest)
//   halt          monitor halt indication
//   commit_valid  one instruction retired this cycle
//   err           error flags, any set bit is an error
//   dut_rst       reset driven to the DUT
//   running       high while the DUT is being run
//   done          sticky completion flag
//   status        0 NONE, 1 PASS, 2 ERROR, 3 TIMEOUT, 4 STALL
//   err_latched   OR of every err bit seen while running/draining
//   cycle_cnt     cycles spent running
//   commit_cnt    commits seen while running
interface tb_run_ctrl_if #(
  parameter int NUM_ERR = 2,
  parameter int CNT_W   = 32
);
  logic               halt;
  logic               commit_valid;
  logic [NUM_ERR-1:0] err;
  logic               dut_rst;
  logic               running;
  logic               done;
  logic [2:0]         status;
  logic [NUM_ERR-1:0] err_latched;
  logic [CNT_W-1:0]   cycle_cnt;
  logic [CNT_W-1:0]   commit_cnt;

  modport master (
    output halt, commit_valid, err,
    input  dut_rst, running, done, status, err_latched, cycle_cnt, commit_cnt
  );

  modport slave (
    input  halt, commit_valid, err,
    output dut_rst, running, done, status, err_latched, cycle_cnt, commit_cnt
  );
endinterface

// File: rtl/tb_run_ctrl.sv
// tb_run_ctrl
//   Simulation run controller: sequences the DUT reset, then watches errors,
//   halt, a global timeout and a commit-stall watchdog. After an error it
//   drains for DRAIN_ERR cycles, then raises a sticky done with a status code.
//   clk  bench clock
//   rst  synchronous active-high reset (restarts the whole sequence)
//   bus  tb_run_ctrl_if.slave: halt/commit_valid/err in, dut_rst/running/done/
//        status/err_latched/cycle_cnt/commit_cnt out
module tb_run_ctrl #(
  parameter int NUM_ERR     = 2,
  parameter int RST_CYCLES  = 5,
  parameter int TIMEOUT     = 10000000,
  parameter int STALL_LIMIT = 0,
  parameter int DRAIN_ERR   = 5,
  parameter int CNT_W       = 32
) (
  input logic          clk,
  input logic          rst,
  tb_run_ctrl_if.slave bus
);

  localparam int HOLD_W  = $clog2(RST_CYCLES + 2);
  localparam int DRAIN_W = $clog2(DRAIN_ERR + 2);

  localparam logic [2:0] ST_NONE    = 3'd0;
  localparam logic [2:0] ST_PASS    = 3'd1;
  localparam logic [2:0] ST_ERROR   = 3'd2;
  localparam logic [2:0] ST_TIMEOUT = 3'd3;
  localparam logic [2:0] ST_STALL   = 3'd4;

  typedef enum logic [1:0] {
    S_RESET_HOLD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [DRAIN_W-1:0] drain_cnt_reg, drain_cnt_next;
  logic [CNT_W-1:0]   stall_cnt_reg, stall_cnt_next;
  logic [CNT_W-1:0]   cycle_cnt_reg, cycle_cnt_next;
  logic [CNT_W-1:0]   commit_cnt_reg, commit_cnt_next;
  logic [2:0]         status_reg, status_next;
  logic [NUM_ERR-1:0] err_latched_reg, err_latched_next;

  // Event detection, only meaningful in RUN
  logic ev_error, ev_halt, ev_timeout, ev_stall;
  logic [CNT_W-1:0] cycle_inc, commit_inc, stall_inc;

  assign ev_error   = |bus.err;
  assign ev_halt    = bus.halt;
  assign ev_timeout = (cycle_cnt_reg == CNT_W'(TIMEOUT - 1));
  // stall_cnt counts the no-commit cycles before this one; a further empty
  // cycle completes a window of STALL_LIMIT cycles without progress.
  assign ev_stall   = (STALL_LIMIT != 0) && !bus.commit_valid &&
                      (stall_cnt_reg == CNT_W'(STALL_LIMIT - 1));

  // Saturating increments
  assign cycle_inc  = (&cycle_cnt_reg) ? cycle_cnt_reg : cycle_cnt_reg + 1'b1;
  assign commit_inc = (bus.commit_valid && !(&commit_cnt_reg)) ?
                      commit_cnt_reg + 1'b1 : commit_cnt_reg;
  assign stall_inc  = (&stall_cnt_reg) ? stall_cnt_reg : stall_cnt_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_RESET_HOLD;
      hold_cnt_reg    <= '0;
      drain_cnt_reg   <= '0;
      stall_cnt_reg   <= '0;
      cycle_cnt_reg   <= '0;
      commit_cnt_reg  <= '0;
      status_reg      <= ST_NONE;
      err_latched_reg <= '0;
    end else begin
      state_reg       <= state_next;
      hold_cnt_reg    <= hold_cnt_next;
      drain_cnt_reg   <= drain_cnt_next;
      stall_cnt_reg   <= stall_cnt_next;
      cycle_cnt_reg   <= cycle_cnt_next;
      commit_cnt_reg  <= commit_cnt_next;
      status_reg      <= status_next;
      err_latched_reg <= err_latched_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    hold_cnt_next    = hold_cnt_reg;
    drain_cnt_next   = drain_cnt_reg;
    stall_cnt_next   = stall_cnt_reg;
    cycle_cnt_next   = cycle_cnt_reg;
    commit_cnt_next  = commit_cnt_reg;
    status_next      = status_reg;
    err_latched_next = err_latched_reg;

    case (state_reg)
      S_RESET_HOLD: begin
        hold_cnt_next = hold_cnt_reg + 1'b1;
        if (hold_cnt_reg == HOLD_W'(RST_CYCLES - 1)) begin
          state_next = S_RUN;
        end
      end

      S_RUN: begin
        err_latched_next = err_latched_reg | bus.err;
        // A commit on the event cycle still retired, so it is counted;
        // cycle_cnt freezes at the value it held when the event hit.
        commit_cnt_next  = commit_inc;
        if (ev_error) begin
          status_next    = ST_ERROR;
          drain_cnt_next = '0;
          state_next     = (DRAIN_ERR > 0) ? S_DRAIN : S_DONE;
        end else if (ev_halt) begin
          status_next = ST_PASS;
          state_next  = S_DONE;
        end else if (ev_timeout) begin
          status_next = ST_TIMEOUT;
          state_next  = S_DONE;
        end else if (ev_stall) begin
          status_next = ST_STALL;
          state_next  = S_DONE;
        end else begin
          cycle_cnt_next = cycle_inc;
          stall_cnt_next = bus.commit_valid ? '0 : stall_inc;
        end
      end

      S_DRAIN: begin
        err_latched_next = err_latched_reg | bus.err;
        drain_cnt_next   = drain_cnt_reg + 1'b1;
        if (drain_cnt_reg == DRAIN_W'(DRAIN_ERR - 1)) begin
          state_next = S_DONE;
        end
      end

      S_DONE: begin
        // terminal until rst
      end

      default: state_next = S_RESET_HOLD;
    endcase
  end

  assign bus.dut_rst     = (state_reg == S_RESET_HOLD);
  assign bus.running     = (state_reg == S_RUN);
  assign bus.done        = (state_reg == S_DONE);
  assign bus.status      = status_reg;
  assign bus.err_latched = err_latched_reg;
  assign bus.cycle_cnt   = cycle_cnt_reg;
  assign bus.commit_cnt  = commit_cnt_reg;

endmodule

// File: tb/tb_tb_run_ctrl.sv
// tb_tb_run_ctrl
//   Randomised + directed bench for tb_run_ctrl. Each run's stimulus is laid
//   out in per-RUN-cycle arrays; a reference model scans them for the first
//   event and pushes the expected outcome. A monitor pops on every rising done
//   and also checks reset values and reset-hold length.
module tb_tb_run_ctrl;
  localparam int NE    = 2;
  localparam int RSTC  = 5;
  localparam int TMO   = 50;
  localparam int STALL = 8;
  localparam int DRAIN = 5;
  localparam int CW    = 32;
  localparam int LEN   = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tb_run_ctrl_if #(.NUM_ERR(NE), .CNT_W(CW)) bus ();

  tb_run_ctrl #(
    .NUM_ERR(NE), .RST_CYCLES(RSTC), .TIMEOUT(TMO),
    .STALL_LIMIT(STALL), .DRAIN_ERR(DRAIN), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [2:0]    status;
    logic [NE-1:0] errl;
    int            cyc;
    int            com;
    int            lat;
  } exp_t;

  exp_t          sb_q[$];
  int            tests = 0;
  int            fails = 0;
  logic          c_arr[LEN];
  logic          h_arr[LEN];
  logic [NE-1:0] e_arr[LEN];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected outcome from the stimulus arrays: first cycle with any event,
  // resolved by priority; drain widens err_latched by the following cycles.
  function automatic exp_t model();
    exp_t r;
    int   last_commit = -1;
    int   ncom = 0;
    r.status = 3'd0; r.errl = '0; r.cyc = 0; r.com = 0; r.lat = 0;
    for (int k = 0; k < LEN; k++) begin
      logic ev_e, ev_h, ev_t, ev_s;
      ev_e = |e_arr[k];
      ev_h = h_arr[k];
      ev_t = (k == TMO - 1);
      ev_s = !c_arr[k] && ((k - last_commit) == STALL);
      if (c_arr[k]) ncom++;
      if (ev_e || ev_h || ev_t || ev_s) begin
        r.cyc  = k;
        r.com  = ncom;
        r.errl = e_arr[k];
        r.lat  = k + 1;
        if (ev_e) begin
          r.status = 3'd2;
          for (int d = 1; d <= DRAIN; d++)
            if (k + d < LEN) r.errl |= e_arr[k + d];
          r.lat += DRAIN;
        end else if (ev_h) r.status = 3'd1;
        else if (ev_t)     r.status = 3'd3;
        else               r.status = 3'd4;
        return r;
      end
      if (c_arr[k]) last_commit = k;
    end
    return r;
  endfunction

  task automatic clear_arrays();
    for (int k = 0; k < LEN; k++) begin
      c_arr[k] = 1'b0; h_arr[k] = 1'b0; e_arr[k] = '0;
    end
  endtask

  task automatic junk();
    bus.halt         = 1'($urandom_range(0, 1));
    bus.commit_valid = 1'($urandom_range(0, 1));
    bus.err          = NE'($urandom);
  endtask

  task automatic apply(input int k);
    bus.halt         = h_arr[k];
    bus.commit_valid = c_arr[k];
    bus.err          = e_arr[k];
  endtask

  // abort_at < 0: normal run; otherwise rst is raised at that RUN/DRAIN cycle.
  task automatic do_run(input int abort_at);
    exp_t e;
    int   i;
    e.lat = LEN;
    if (abort_at < 0) begin
      e = model();
      sb_q.push_back(e);
    end
    rst = 1'b1;
    junk();
    repeat (3) begin @(posedge clk); #1; junk(); end
    rst = 1'b0;
    // halt/err/commit are ignored while the DUT reset is held
    for (i = 0; i < RSTC; i++) begin
      @(posedge clk); #1;
      if (i < RSTC - 1) junk();
    end
    for (int k = 0; k < LEN; k++) begin
      if (k == abort_at) return;   // next do_run raises rst immediately
      apply(k);
      @(posedge clk); #1;
      if (k + 1 >= e.lat) break;
    end
    i = 0;
    while (!bus.done && i < 20) begin @(posedge clk); #1; i++; end
    check("done_seen", bus.done, 1);
    repeat (2) begin junk(); @(posedge clk); #1; end
  endtask

  task automatic gen_random();
    int p;
    clear_arrays();
    case ($urandom_range(0, 3))
      0: p = 0;
      1: p = 40;
      2: p = 80;
      default: p = 100;
    endcase
    for (int k = 0; k < LEN; k++) begin
      c_arr[k] = ($urandom_range(0, 99) < p);
      h_arr[k] = ($urandom_range(0, 99) < 2);
      for (int b = 0; b < NE; b++) e_arr[k][b] = ($urandom_range(0, 99) < 2);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    bit   seen, rst_e;
    logic prev_dr, prev_done;
    int   hold_e, run_e;
    exp_t e;
    seen = 0; prev_dr = 1'b0; prev_done = 1'b0; hold_e = 0; run_e = 0;
    forever begin
      @(posedge clk);
      rst_e = rst;
      @(negedge clk);
      if (rst_e) begin
        seen = 1; hold_e = 0; run_e = 0;
        check("rst_dut_rst", bus.dut_rst, 1);
        check("rst_running", bus.running, 0);
        check("rst_done", bus.done, 0);
        check("rst_status", bus.status, 0);
        check("rst_err_latched", bus.err_latched, 0);
        check("rst_cycle_cnt", bus.cycle_cnt, 0);
        check("rst_commit_cnt", bus.commit_cnt, 0);
      end else if (seen) begin
        if (prev_dr) hold_e++;
        if (prev_dr && !bus.dut_rst) begin
          check("hold_edges", hold_e, RSTC);
          check("run_running", bus.running, 1);
          check("run_cycle_cnt0", bus.cycle_cnt, 0);
          check("run_commit_cnt0", bus.commit_cnt, 0);
          run_e = 0;
        end else if (!bus.dut_rst) begin
          run_e++;
        end
        if (!prev_done && bus.done) begin
          check("sb_has_entry", sb_q.size() > 0, 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("status", bus.status, e.status);
            check("err_latched", bus.err_latched, e.errl);
            check("cycle_cnt", bus.cycle_cnt, e.cyc);
            check("commit_cnt", bus.commit_cnt, e.com);
            check("done_latency", run_e, e.lat);
            check("done_running", bus.running, 0);
            check("done_dut_rst", bus.dut_rst, 0);
            $display("[TB] run done: status=%0d err_latched=%0b cycle_cnt=%0d commit_cnt=%0d latency=%0d",
                     bus.status, bus.err_latched, bus.cycle_cnt, bus.commit_cnt, run_e);
          end
        end
        if (prev_done) check("done_sticky", bus.done, 1);
      end
      prev_dr   = bus.dut_rst;
      prev_done = bus.done;
    end
  end

  // Stimulus
  initial begin
    bus.halt = 1'b0; bus.commit_valid = 1'b0; bus.err = '0;
    @(posedge clk); #1;

    // halt pass: 10 commits, halt at RUN cycle 20
    clear_arrays();
    for (int k = 1; k < 20; k += 2) c_arr[k] = 1'b1;
    h_arr[20] = 1'b1;
    do_run(-1);

    // error drain: err 01 then 10 two cycles later, halt ignored in drain
    clear_arrays();
    for (int k = 0; k < LEN; k++) c_arr[k] = 1'b1;
    e_arr[7] = 2'b01; e_arr[9] = 2'b10; h_arr[10] = 1'b1;
    do_run(-1);

    // timeout: steady commits, no events
    clear_arrays();
    for (int k = 0; k < LEN; k++) c_arr[k] = 1'b1;
    do_run(-1);

    // stall: no commits at all
    clear_arrays();
    do_run(-1);

    // priority: halt and err together -> ERROR
    clear_arrays();
    for (int k = 0; k < LEN; k++) c_arr[k] = 1'b1;
    h_arr[4] = 1'b1; e_arr[4] = 2'b10;
    do_run(-1);

    // priority: halt on the timeout cycle -> PASS, commit on that cycle counted
    clear_arrays();
    for (int k = 0; k < LEN; k++) c_arr[k] = 1'b1;
    h_arr[TMO - 1] = 1'b1;
    do_run(-1);

    // priority: halt on the stall cycle -> PASS
    clear_arrays();
    h_arr[STALL - 1] = 1'b1;
    do_run(-1);

    // mid-run reset during drain, then a clean full run
    clear_arrays();
    for (int k = 0; k < LEN; k++) c_arr[k] = 1'b1;
    e_arr[3] = 2'b11;
    do_run(5);
    clear_arrays();
    for (int k = 0; k < 12; k++) c_arr[k] = 1'b1;
    h_arr[12] = 1'b1;
    do_run(-1);

    for (int r = 0; r < 30; r++) begin
      gen_random();
      do_run(-1);
    end

    repeat (5) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
